// File: rtl/instr_stream_responder.sv
// instr_stream_responder
// Responder side of the syn/ack/last instruction-streaming handshake.
// A small writable store is loaded through the programming port while idle.
// While the initiator holds syn high, sequential words are returned with one
// ack pulse per word, and last marks the final word of the program.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for syn; programming port writes accepted here only
// STREAM | syn held; LAT wait cycles before each word, then one word issued
// DONE   | final word issued; instr holds it until the initiator drops syn
//
// Timing: the IDLE edge that samples syn=1 issues nothing. LAT wait edges
// follow, then the issuing edge sets ack. A consumer sampling on its own
// edges therefore sees the first ack LAT+2 edges after that IDLE edge.
module instr_stream_responder #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 64,
  parameter int LAT    = 0
) (
  input  logic                       s_clk,
  input  logic                       s_rst,
  input  logic                       s_i_syn,
  output logic [IWIDTH-1:0]          s_o_instr,
  output logic                       s_o_ack,
  output logic                       s_o_last,
  input  logic                       s_i_we,
  input  logic [$clog2(DEPTH)-1:0]   s_i_waddr,
  input  logic [IWIDTH-1:0]          s_i_wdata,
  input  logic [$clog2(DEPTH):0]     s_i_len,
  output logic                       s_o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]  LAT_C   = LAT[3:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IWIDTH-1:0] mem [DEPTH];

  logic [AW:0]       ptr;
  logic [AW:0]       ptr_nx;
  logic [AW:0]       len_q;
  logic [AW:0]       len_nx;
  logic [3:0]        wcnt;
  logic [3:0]        wcnt_nx;
  logic [IWIDTH-1:0] instr_nx;
  logic              ack_nx;
  logic              last_nx;
  logic              busy_nx;

  logic              wait_done;
  logic              word_is_last;
  logic [IWIDTH-1:0] word;

  // A zero-length program still issues one (empty) word, flagged last.
  assign wait_done    = (wcnt >= LAT_C);
  assign word_is_last = (len_q == '0) || (ptr == (len_q - ONE_C));
  assign word         = (len_q == '0) ? '0 : mem[ptr[AW-1:0]];

  // Store write port: only accepted while idle; contents survive reset.
  always_ff @(posedge s_clk) begin
    if (s_i_we && (state == ST_IDLE)) begin
      mem[s_i_waddr] <= s_i_wdata;
    end
  end

  // State register.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; dropping syn mid-stream aborts even on an issue edge.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (s_i_syn) state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        if (!s_i_syn) begin
          state_nx = ST_IDLE;
        end else if (wait_done && word_is_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!s_i_syn) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    ptr_nx   = ptr;
    len_nx   = len_q;
    wcnt_nx  = wcnt;
    instr_nx = s_o_instr;
    ack_nx   = 1'b0;
    last_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_i_syn) begin
          len_nx  = (s_i_len > DEPTH_C) ? DEPTH_C : s_i_len;
          ptr_nx  = '0;
          wcnt_nx = '0;
        end
      end
      ST_STREAM: begin
        if (!s_i_syn) begin
          instr_nx = '0;
          ptr_nx   = '0;
          wcnt_nx  = '0;
        end else if (!wait_done) begin
          wcnt_nx = wcnt + 4'd1;
        end else begin
          ack_nx   = 1'b1;
          last_nx  = word_is_last;
          instr_nx = word;
          ptr_nx   = ptr + ONE_C;
          wcnt_nx  = '0;
        end
      end
      ST_DONE: begin
        if (!s_i_syn) ptr_nx = '0;
      end
      default: begin
        ptr_nx  = '0;
        wcnt_nx = '0;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      ptr       <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      s_o_instr <= '0;
      s_o_ack   <= 1'b0;
      s_o_last  <= 1'b0;
      s_o_busy  <= 1'b0;
    end else begin
      ptr       <= ptr_nx;
      len_q     <= len_nx;
      wcnt      <= wcnt_nx;
      s_o_instr <= instr_nx;
      s_o_ack   <= ack_nx;
      s_o_last  <= last_nx;
      s_o_busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_instr_stream_responder.sv
// Directed bench for instr_stream_responder: one instance with LAT=0 and one
// with LAT=2 share the programming port and reset; each has its own syn.
module tb_instr_stream_responder;

  localparam int IW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          syn0 = 1'b0;
  logic          syn2 = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [IW-1:0] wdata = '0;
  logic [AW:0]   len = '0;

  logic [IW-1:0] instr0, instr2;
  logic          ack0, last0, busy0;
  logic          ack2, last2, busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [IW-1:0] prog [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  always #5 clk = ~clk;

  instr_stream_responder #(.IWIDTH(IW), .DEPTH(DEPTH), .LAT(0)) u_lat0 (
    .s_clk(clk), .s_rst(rst_n), .s_i_syn(syn0),
    .s_o_instr(instr0), .s_o_ack(ack0), .s_o_last(last0),
    .s_i_we(we), .s_i_waddr(waddr), .s_i_wdata(wdata), .s_i_len(len),
    .s_o_busy(busy0)
  );

  instr_stream_responder #(.IWIDTH(IW), .DEPTH(DEPTH), .LAT(2)) u_lat2 (
    .s_clk(clk), .s_rst(rst_n), .s_i_syn(syn2),
    .s_o_instr(instr2), .s_o_ack(ack2), .s_o_last(last2),
    .s_i_we(we), .s_i_waddr(waddr), .s_i_wdata(wdata), .s_i_len(len),
    .s_o_busy(busy2)
  );

  // observation vector layout: {busy, ack, last, instr}
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset;
    logic [34:0] exp;
    tick();
    exp = '0;
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL reset_lat0: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    n_cmp++;
    if ({busy2, ack2, last2, instr2} !== exp) begin
      n_fail++;
      $display("FAIL reset_lat2: got %h want %h", {busy2, ack2, last2, instr2}, exp);
    end
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) write_word(i[AW-1:0], prog[i]);
  endtask

  task automatic test_lat0_stream;
    logic [34:0] exp;
    len = 7'd4; syn0 = 1'b1;
    tick();
    exp = {1'b1, 1'b0, 1'b0, 32'h0};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL lat0_start: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b1, 1'b1, (i == 3), prog[i]};
      n_cmp++;
      if ({busy0, ack0, last0, instr0} !== exp) begin
        n_fail++;
        $display("FAIL lat0_word%0d: got %h want %h", i, {busy0, ack0, last0, instr0}, exp);
      end
    end
    tick();
    exp = {1'b1, 1'b0, 1'b0, 32'h44444444};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL lat0_done: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    syn0 = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 1'b0, 32'h44444444};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL lat0_idle: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
  endtask

  task automatic test_lat2_stream;
    logic [34:0] exp;
    logic [IW-1:0] held;
    len = 7'd4; syn2 = 1'b1;
    tick();
    held = instr2;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 2; w++) begin
        tick();
        exp = {1'b1, 1'b0, 1'b0, (i == 0) ? 32'h0 : prog[i-1]};
        n_cmp++;
        if ({busy2, ack2, last2, instr2} !== exp) begin
          n_fail++;
          $display("FAIL lat2_wait%0d_%0d: got %h want %h", i, w, {busy2, ack2, last2, instr2}, exp);
        end
      end
      tick();
      exp = {1'b1, 1'b1, (i == 3), prog[i]};
      n_cmp++;
      if ({busy2, ack2, last2, instr2} !== exp) begin
        n_fail++;
        $display("FAIL lat2_word%0d: got %h want %h", i, {busy2, ack2, last2, instr2}, exp);
      end
    end
    tick();
    exp = {1'b1, 1'b0, 1'b0, 32'h44444444};
    n_cmp++;
    if ({busy2, ack2, last2, instr2} !== exp) begin
      n_fail++;
      $display("FAIL lat2_done: got %h want %h (start instr %h)", {busy2, ack2, last2, instr2}, exp, held);
    end
    syn2 = 1'b0;
    tick();
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat2_idle: got busy=%b want 0", busy2);
    end
  endtask

  task automatic test_abort;
    logic [34:0] exp;
    len = 7'd4; syn0 = 1'b1;
    tick();
    tick();
    tick();
    exp = {1'b1, 1'b1, 1'b0, 32'h22222222};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL abort_pre: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    syn0 = 1'b0;
    tick();
    exp = '0;
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL abort_cut: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_noack: got ack=%b want 0", ack0);
    end
    syn0 = 1'b1;
    tick();
    tick();
    exp = {1'b1, 1'b1, 1'b0, 32'h11111111};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL abort_restart: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    syn0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_len_zero;
    logic [34:0] exp;
    len = 7'd0; syn0 = 1'b1;
    tick();
    tick();
    exp = {1'b1, 1'b1, 1'b1, 32'h0};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL len0_word: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    tick();
    exp = {1'b1, 1'b0, 1'b0, 32'h0};
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL len0_done: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    syn0 = 1'b0;
    tick();
  endtask

  task automatic test_write_during_stream;
    len = 7'd4; syn0 = 1'b1;
    tick();
    we = 1'b1; waddr = 6'd1; wdata = 32'hDEADBEEF;
    tick();
    tick();
    tick();
    we = 1'b0;
    tick();
    tick();
    syn0 = 1'b0;
    tick();
    syn0 = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({ack0, instr0} !== {1'b1, 32'h22222222}) begin
      n_fail++;
      $display("FAIL wr_ignored: got ack=%b instr=%h want ack=1 instr=22222222", ack0, instr0);
    end
    syn0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_len_clamp;
    int n_ack;
    int last_idx;
    logic [IW-1:0] last_word;
    write_word(6'd63, 32'hABCD0063);
    n_ack = 0; last_idx = -1; last_word = '0;
    len = 7'd100; syn0 = 1'b1;
    tick();
    len = 7'd4;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (ack0) begin
        n_ack++;
        if (last0) begin
          last_idx  = n_ack;
          last_word = instr0;
        end
      end
    end
    n_cmp++;
    if (n_ack !== 64) begin
      n_fail++;
      $display("FAIL clamp_count: got %0d acks want 64", n_ack);
    end
    n_cmp++;
    if ({last_idx, last_word} !== {32'd64, 32'hABCD0063}) begin
      n_fail++;
      $display("FAIL clamp_last: got idx=%0d word=%h want idx=64 word=abcd0063", last_idx, last_word);
    end
    syn0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream;
    logic [34:0] exp;
    len = 7'd4; syn0 = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp = '0;
    n_cmp++;
    if ({busy0, ack0, last0, instr0} !== exp) begin
      n_fail++;
      $display("FAIL rst_async: got %h want %h", {busy0, ack0, last0, instr0}, exp);
    end
    syn0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    syn0 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b1, 1'b1, (i == 3), prog[i]};
      n_cmp++;
      if ({busy0, ack0, last0, instr0} !== exp) begin
        n_fail++;
        $display("FAIL rst_replay%0d: got %h want %h", i, {busy0, ack0, last0, instr0}, exp);
      end
    end
    syn0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lat0_stream();
    test_lat2_stream();
    test_abort();
    test_len_zero();
    test_write_during_stream();
    test_len_clamp();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_stream_responder.md
Name: instr_stream_responder

Overview:
- Responder end of the syn/ack/last instruction-streaming handshake used by the fetch stage.
- Holds a small writable instruction store; while the initiator holds syn high it returns sequential words, one ack pulse per word, flagging the final word with last.
- A programming port loads the store and the program length between streams.
- Sits between the fetch stage and the testbench/boot loader.

Parameters:
- IWIDTH, 32, instruction word width.
- DEPTH, 64, number of store entries (power of 2, >= 2).
- LAT, 0, wait cycles inserted before each word (0..15).

Ports:
- s_clk  input  1  clock; all logic on rising edge.
- s_rst  input  1  asynchronous, active-low reset.
- s_i_syn  input  1  initiator request; high = stream words.
- s_o_instr  output  IWIDTH  returned instruction word.
- s_o_ack  output  1  one-cycle pulse: s_o_instr valid this cycle.
- s_o_last  output  1  high only together with s_o_ack on the final word.
- s_i_we  input  1  store write enable.
- s_i_waddr  input  log2(DEPTH)  store write address.
- s_i_wdata  input  IWIDTH  store write data.
- s_i_len  input  log2(DEPTH)+1  program length in words.
- s_o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, s_rst=0): state IDLE; ptr=0, wcnt=0, len_q=0; s_o_instr=0, s_o_ack=0, s_o_last=0, s_o_busy=0. Store array is not reset; contents survive reset.
- Interface fixed: one clock s_clk; reset s_rst asynchronous, active-low.
- All outputs are registered. ptr is log2(DEPTH)+1 bits. wcnt is 4 bits.
- Store writes happen only in IDLE with s_i_we=1: mem[s_i_waddr] <= s_i_wdata. Writes in any other state are dropped.
- IDLE:
  - s_i_syn=0: stay in IDLE.
  - s_i_syn=1: latch len_q = min(s_i_len, DEPTH), set ptr=0, wcnt=0, go to STREAM.
  - The transition edge itself issues no word.
- STREAM, s_i_syn=1, wcnt<LAT: wcnt++; ack=0, last=0.
- STREAM, s_i_syn=1, wcnt==LAT: issue a word.
  - s_o_ack<=1, s_o_instr<=mem[ptr], s_o_last<=(ptr==len_q-1), ptr++, wcnt<=0.
  - If the word is last, go to DONE.
- STREAM with len_q==0: the first issue returns s_o_instr=0 with ack=1 and last=1, then goes to DONE.
- Latency:
  - First ack arrives LAT+2 edges after the edge that first samples syn=1.
  - Later words arrive every LAT+1 cycles.
  - With LAT=0, ack is continuous, one word per cycle.
- DONE: ack=0, last=0, s_o_instr holds the final word. Stay in DONE until s_i_syn=0, then go to IDLE with ptr=0.
- Abort (s_i_syn=0 sampled in STREAM): go to IDLE next edge; ack=0, last=0, s_o_instr<=0, ptr=0, wcnt=0. Any word not yet issued is never returned.
- s_i_syn=0 on the same edge a word would issue: the abort wins and no ack is produced.
- s_o_ack, s_o_last: single-cycle pulses. s_o_last is never high without s_o_ack.
- s_o_instr: holds the last issued word between acks. Cleared only on reset or abort.
- s_i_len changes during STREAM/DONE have no effect; the length is taken from len_q.
- s_i_len > DEPTH: clamped to DEPTH, so the stream ends at address DEPTH-1 with no wrap.
- Reset asserted mid-stream: outputs go to reset values immediately and asynchronously. The next stream starts from ptr=0.

Test Plan:
- Reset, then in IDLE write mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444 and set len=4, LAT=0; raise syn -> ack high 4 consecutive cycles with those words in order, last high only with 0x44444444, state DONE, busy=1; drop syn -> busy=0 next cycle.
- Same program with LAT=2 -> each word preceded by 2 idle cycles (ack=0), 3-cycle spacing between acks, last only on the 4th word.
- Abort: syn dropped after the 2nd ack -> no further ack, s_o_instr=0 next cycle. Raise syn again -> first word returned is 0x11111111.
- len=0 -> single ack with s_o_instr=0 and last=1, then DONE. len=100 with DEPTH=64 -> exactly 64 acks, last on address 63.
- Write attempted during STREAM to addr 1 with 0xDEADBEEF -> ignored; the next stream still returns 0x22222222 at position 1.
- Assert s_rst mid-stream after 1 ack -> ack, last and instr are 0 immediately. After release, a new stream replays from address 0 and the store contents are intact.
